// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx_v2 receiver and its companion blocks:
// parity modes, receive FSM encoding and the flag-word width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Queued word is {break, frame_err, parity_err, data}.
  function automatic int flag_word_width(input int data_bits);
    return data_bits + 3;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO: the head entry is visible whenever not empty.
// A write while full is accepted only if a read frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_rd, do_wr;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign count_d   = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_v2.sv
// Parametrised UART receiver: synchroniser, false-start rejection, parity /
// framing / break detection, and an FWFT queue with sticky overrun.
module uart_rx_v2 import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  input  logic                 i_Clear_Overrun,
  output logic                 o_Busy
);

  localparam int WW = flag_word_width(DATA_BITS);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e            state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, par_err_q, frame_err_q, overrun_q;

  logic                 half_tick, full_tick, push, frame_err_fin, brk;
  logic                 full, empty, pop;
  logic [WW-1:0]        push_word, head_word;

  assign half_tick     = (cnt_q == HALF_M1);
  assign full_tick     = (cnt_q == FULL_M1);
  assign push          = (state_q == ST_STOP) && full_tick && (stop_q == 1'(STOP_BITS - 1));
  assign frame_err_fin = frame_err_q | ~rx_s_q;
  // par_bit_q stays 0 when parity is disabled, so it never masks a break.
  assign brk           = (shift_q == '0) && !par_bit_q && frame_err_fin;
  assign push_word     = {brk, frame_err_fin, par_err_q, shift_q};

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q     <= ST_START;
            cnt_q       <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        ST_START: begin
          if (half_tick) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (full_tick) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            cnt_q     <= '0;
            par_bit_q <= rx_s_q;
            par_err_q <= (PARITY == PAR_ODD) ? ~((^shift_q) ^ rx_s_q)
                                             :  ((^shift_q) ^ rx_s_q);
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            cnt_q <= '0;
            if (!rx_s_q) frame_err_q <= 1'b1;
            // Return to IDLE at mid-stop so a back-to-back start edge is caught.
            if (push) state_q <= ST_IDLE;
            else      stop_q  <= stop_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop = o_Rx_Valid & i_Rx_Ready;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L)                   overrun_q <= 1'b0;
    else if (push && full && !pop)  overrun_q <= 1'b1;
    else if (i_Clear_Overrun)       overrun_q <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_Clock),
    .rst_ni    (i_Rst_L),
    .wr_en_i   (push),
    .wr_data_i (push_word),
    .rd_en_i   (i_Rx_Ready),
    .rd_data_o (head_word),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign o_Rx_Valid = ~empty;
  assign {o_Break, o_Frame_Err, o_Parity_Err, o_Rx_Byte} = head_word;
  assign o_Overrun  = overrun_q;
  assign o_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed bench for uart_rx_v2: an 8N1 instance and an 8E1 instance,
// both at 16 clocks per bit, sharing clock and reset.
module tb_uart_rx_v2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t_fall = 0;

  logic rx_n, ready_n, clr_n, valid_n, perr_n, ferr_n, brk_n, ovr_n, busy_n;
  logic rx_e, ready_e, clr_e, valid_e, perr_e, ferr_e, brk_e, ovr_e, busy_e;
  logic [7:0] byte_n, byte_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_v2 #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_n), .o_Rx_Valid(valid_n),
    .i_Rx_Ready(ready_n), .o_Rx_Byte(byte_n), .o_Parity_Err(perr_n), .o_Frame_Err(ferr_n),
    .o_Break(brk_n), .o_Overrun(ovr_n), .i_Clear_Overrun(clr_n), .o_Busy(busy_n)
  );

  uart_rx_v2 #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_e), .o_Rx_Valid(valid_e),
    .i_Rx_Ready(ready_e), .o_Rx_Byte(byte_e), .o_Parity_Err(perr_e), .o_Frame_Err(ferr_e),
    .o_Break(brk_e), .o_Overrun(ovr_e), .i_Clear_Overrun(clr_e), .o_Busy(busy_e)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_n = v;
    else            rx_e = v;
  endtask

  task automatic hold_bit(input int which, input logic v);
    set_line(which, v);
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic use_par,
                            input logic par, input logic stop);
    @(posedge clk); #1;
    t_fall = cyc;
    hold_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(which, data[i]);
    if (use_par) hold_bit(which, par);
    hold_bit(which, stop);
    set_line(which, 1'b1);
  endtask

  // Sends a frame while watching for the head word; ready must be high.
  task automatic rx_check(input string tag, input int which, input logic [7:0] data,
                          input logic use_par, input logic par, input logic stop,
                          input logic [7:0] exp_byte, input logic exp_pe,
                          input logic exp_fe, input logic exp_brk);
    logic        found;
    int          at;
    logic [10:0] head;
    logic        valid_after;
    found = 1'b0; at = 0; head = '0; valid_after = 1'b1;
    fork
      send_frame(which, data, use_par, par, stop);
      begin
        for (int i = 0; i < 300 && !found; i++) begin
          @(posedge clk); #1;
          if ((which == 0) ? valid_n : valid_e) begin
            found = 1'b1;
            at    = cyc;
            head  = (which == 0) ? {brk_n, ferr_n, perr_n, byte_n} : {brk_e, ferr_e, perr_e, byte_e};
          end
        end
        if (found) begin
          @(posedge clk); #1;
          valid_after = (which == 0) ? valid_n : valid_e;
        end
      end
    join
    check_eq({tag, "_found"}, 32'(found), 32'd1);
    check_eq({tag, "_latency"}, at - t_fall, use_par ? 32'd171 : 32'd155);
    check_eq({tag, "_byte"}, 32'(head[7:0]), 32'(exp_byte));
    check_eq({tag, "_perr"}, 32'(head[8]), 32'(exp_pe));
    check_eq({tag, "_ferr"}, 32'(head[9]), 32'(exp_fe));
    check_eq({tag, "_brk"}, 32'(head[10]), 32'(exp_brk));
    check_eq({tag, "_one_cycle"}, 32'(valid_after), 32'd0);
    repeat (30) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_n = 1'b1; rx_e = 1'b1;
    ready_n = 1'b0; ready_e = 1'b0; clr_n = 1'b0; clr_e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid_n), 32'd0);
    check_eq("rst_byte", 32'(byte_n), 32'd0);
    check_eq("rst_flags", 32'({perr_n, ferr_n, brk_n, ovr_n}), 32'd0);
    check_eq("rst_busy", 32'(busy_n), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    ready_n = 1'b1; ready_e = 1'b1;
    rx_check("a5", 0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    rx_check("par_bad", 1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    rx_check("par_ok", 1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    rx_check("par_ok7", 1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    rx_check("break", 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    rx_check("frame55", 0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);

    // Short low pulse must be rejected as a false start.
    ready_n = 1'b0;
    @(posedge clk); #1;
    set_line(0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    check_eq("glitch_busy_hi", 32'(busy_n), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check_eq("glitch_busy_lo", 32'(busy_n), 32'd0);
    check_eq("glitch_no_push", 32'(valid_n), 32'd0);

    for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    check_eq("fill_valid", 32'(valid_n), 32'd1);
    check_eq("fill_no_ovr", 32'(ovr_n), 32'd0);
    send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("ovr_set", 32'(ovr_n), 32'd1);
    ready_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_valid", 32'(valid_n), 32'd1);
      check_eq("drain_byte", 32'(byte_n), 32'(i));
      @(posedge clk); #1;
    end
    check_eq("drain_empty", 32'(valid_n), 32'd0);
    check_eq("ovr_sticky", 32'(ovr_n), 32'd1);
    clr_n = 1'b1;
    @(posedge clk); #1;
    clr_n = 1'b0;
    check_eq("ovr_clear", 32'(ovr_n), 32'd0);

    // Reset in the middle of data bit 3 of a 0x3C frame, with a word queued.
    ready_n = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check_eq("pre_rst_byte", 32'(byte_n), 32'h11);
    @(posedge clk); #1;
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b1);
    set_line(0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 32'(busy_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(valid_n), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_n), 32'd0);
    check_eq("mid_rst_byte", 32'(byte_n), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("post_rst_no_push", 32'(valid_n), 32'd0);
    ready_n = 1'b1;
    rx_check("after_rst", 0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_v2.md
# uart_rx_v2

Parametrised UART receiver, successor to the fixed 8N1 receiver used by board bring-up tops. It adds configurable data width, parity, stop bits and oversampling, plus an input synchroniser and false-start rejection. Each received word carries parity, framing and break flags and is queued in a first-word-fall-through (FWFT) FIFO behind a valid/ready handshake. It sits between the board RX pin and any consumer: LED debug tops, command decoders, or the future UART bridge.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per bit, even, ≥ 8.
- DATA_BITS, default 8: payload width, 5..9.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: 1 or 2.
- FIFO_DEPTH, default 4: power of 2, ≥ 2.

Ports:
- i_Clock  in  1  the block's single clock.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Rx_Serial  in  1  raw asynchronous serial line, idle high.
- o_Rx_Valid  out  1  FIFO head valid.
- i_Rx_Ready  in  1  consumer accepts the head word.
- o_Rx_Byte  out  DATA_BITS  head payload, LSB received first.
- o_Parity_Err  out  1  head word parity mismatch; always 0 when PARITY = 0.
- o_Frame_Err  out  1  head word had at least one stop bit sampled low.
- o_Break  out  1  head word had all-zero data, zero parity (if enabled) and low stop.
- o_Overrun  out  1  sticky: a word was dropped because the FIFO was full.
- i_Clear_Overrun  in  1  clears o_Overrun.
- o_Busy  out  1  receive FSM not in IDLE.

## Operation
- A 2-flop synchroniser feeds rx_s; its flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s = 0 → START, counter = 0.
  - START: sample when counter = CLKS_PER_BIT/2−1. Low → DATA with counter = 0. High → IDLE (glitch, nothing pushed).
  - DATA: sample when counter = CLKS_PER_BIT−1, shift LSB-first. After DATA_BITS samples → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: one sample; compare against XOR of the data (odd: data^p must be 1; even: 0).
  - STOP: sample STOP_BITS times at CLKS_PER_BIT spacing; any low sample sets frame_err.
  - After the last stop sample, push {break, frame_err, parity_err, data} and go directly to IDLE. IDLE is entered at mid-stop so the receiver resynchronises on back-to-back frames.
- A frame is always pushed, even with errors. Glitches are never pushed.
- FIFO behaviour:
  - Pop on o_Rx_Valid & i_Rx_Ready.
  - Push when full with no pop that cycle: word dropped, o_Overrun set.
  - Push and pop in the same cycle when full: both succeed.
  - Pop when empty: ignored.
- o_Overrun: set has priority over i_Clear_Overrun in the same cycle.
- Reset values: o_Rx_Valid 0, o_Rx_Byte 0, all flags 0, o_Busy 0, FSM IDLE, FIFO empty, pointers 0.
- Reset mid-frame aborts the frame; nothing is pushed. After release, a line still low is treated as a new start.

## Timing
- Define T0 as the first cycle rx_s = 0, which is 2 cycles after the pin falls.
- Start check at T0+CLKS_PER_BIT/2.
- Data bit n (0-based) sampled at T0+CLKS_PER_BIT/2+(n+1)·CLKS_PER_BIT. Parity and stop bits follow at the same spacing.
- o_Rx_Valid rises 1 cycle after the final stop sample (FWFT registered output).
  - 8N1 with CLKS_PER_BIT = 16: pin falls at cycle 0, o_Rx_Valid at cycle 155.
- After a pop, the next head is presented on the following cycle.
- Throughput: one word per frame. A full frame's worth of consumer stall is absorbed per FIFO entry.

## Structure
- Shared package uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state encoding;
  - a helper function for the flag-word width (DATA_BITS+3).
- Sub-module uart_rx_fifo: a parametrised width/depth FWFT FIFO with full/empty. It is reusable for the future uart_tx_v2.
- Synchroniser, bit counter, FSM and shifter live in uart_rx_v2.

## Test plan
- 8N1, CLKS_PER_BIT = 16, send 0xA5, ready high → o_Rx_Valid at cycle 155, o_Rx_Byte = 0xA5, all flags 0, single-cycle valid.
- PARITY = 2, 8E1, send 0x03 with parity bit 1 → o_Parity_Err = 1, data 0x03. Correct parity 0 → flag 0.
- 8N1, stop bit driven low, data 0x00 → o_Frame_Err = 1, o_Break = 1. Data 0x55 with stop low → o_Frame_Err = 1, o_Break = 0.
- 5-cycle low pulse on the pin (CLKS_PER_BIT = 16) → FSM returns to IDLE, no push, o_Busy drops.
- FIFO_DEPTH = 4, ready low, send 5 frames 0x01..0x05 → o_Overrun = 1, FIFO holds 0x01..0x04. Drain with ready high → 4 pops in 4 cycles. Pulse i_Clear_Overrun → o_Overrun = 0.
- Assert i_Rst_L low during DATA bit 3 → outputs reset immediately, no word pushed. A following clean 0x3C frame is received correctly.
